// File: rtl/sbox_layer_serial.sv
// Nibble-serial S-box layer: one 4-bit S-box cell substitutes a state word one nibble per clock,
// with valid/ready handshakes on both the input and output words.
module sbox_layer_serial #(
   parameter  int NIBBLES = 16,
   localparam int W       = 4 * NIBBLES,
   localparam int CW      = $clog2(NIBBLES)
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [W-1:0] in_data,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] out_data,
   output logic         busy
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t        state, state_nxt;
   logic [CW-1:0] cnt;
   logic [W-1:0]  shreg;
   logic          load, step, last;

   function automatic logic [3:0] sbox(input logic [3:0] x);
      logic [3:0] y;
      case (x)
         4'h0: y = 4'h0;  4'h1: y = 4'h6;  4'h2: y = 4'he;  4'h3: y = 4'h1;
         4'h4: y = 4'hf;  4'h5: y = 4'h4;  4'h6: y = 4'h7;  4'h7: y = 4'hd;
         4'h8: y = 4'h9;  4'h9: y = 4'h8;  4'ha: y = 4'hc;  4'hb: y = 4'h5;
         4'hc: y = 4'h2;  4'hd: y = 4'ha;  4'he: y = 4'h3;  default: y = 4'hb;
      endcase
      return y;
   endfunction

   assign last     = (cnt == CW'(NIBBLES - 1));
   assign out_data = shreg;

   always_comb begin
      state_nxt = state;
      load      = 1'b0;
      step      = 1'b0;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      busy      = 1'b0;
      case (state)
         IDLE: begin
            in_ready = rst_n;
            if (in_valid) begin
               load      = 1'b1;
               state_nxt = RUN;
            end
         end
         RUN: begin
            busy = 1'b1;
            step = 1'b1;
            if (last) state_nxt = DONE;
         end
         DONE: begin
            out_valid = 1'b1;
            // output transfer and next acceptance share one edge
            in_ready  = out_ready;
            if (out_ready) begin
               if (in_valid) begin
                  load      = 1'b1;
                  state_nxt = RUN;
               end else begin
                  state_nxt = IDLE;
               end
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= IDLE;
         cnt   <= '0;
         shreg <= '0;
      end else begin
         state <= state_nxt;
         if (load) begin
            shreg <= in_data;
            cnt   <= '0;
         end else if (step) begin
            shreg <= {sbox(shreg[3:0]), shreg[W-1:4]};
            cnt   <= last ? '0 : cnt + CW'(1);
         end
      end
   end

endmodule

// File: tb/tb_sbox_layer_serial.sv
// Directed bench for sbox_layer_serial at NIBBLES=16.
module tb_sbox_layer_serial;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [63:0] in_data;
   logic        out_valid;
   logic        out_ready;
   logic [63:0] out_data;
   logic        busy;

   int unsigned n_chk  = 0;
   int unsigned n_pass = 0;

   logic [3:0] sb [16] = '{4'h0, 4'h6, 4'he, 4'h1, 4'hf, 4'h4, 4'h7, 4'hd,
                           4'h9, 4'h8, 4'hc, 4'h5, 4'h2, 4'ha, 4'h3, 4'hb};

   sbox_layer_serial #(.NIBBLES(16)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, got, exp);
   endtask

   function automatic logic [63:0] model(input logic [63:0] x);
      logic [63:0] y;
      for (int i = 0; i < 16; i++) y[4*i +: 4] = sb[x[4*i +: 4]];
      return y;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // present a word and return just after its acceptance edge
   task automatic send(input string tag, input logic [63:0] d);
      int unsigned t;
      in_valid = 1'b1;
      in_data  = d;
      t = 0;
      while (!in_ready && t < 50) begin
         tick();
         t++;
      end
      chk({tag, "_accept"}, 64'(in_ready), 64'd1);
      tick();
      in_valid = 1'b0;
   endtask

   // count cycles from the acceptance edge until out_valid; optionally scramble in_data
   task automatic wait_out(input bit scramble, output int unsigned cyc, output int unsigned bcyc);
      cyc  = 0;
      bcyc = 0;
      while (!out_valid && cyc < 100) begin
         if (busy) bcyc++;
         if (scramble) in_data = {$urandom, $urandom};
         tick();
         cyc++;
      end
   endtask

   initial begin
      int unsigned cyc, bcyc, bad;
      logic [63:0] held, w;

      rst_n = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
      tick();
      tick();
      chk("rst_in_ready", 64'(in_ready), 64'd0);
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_out_data", out_data, 64'h0);
      rst_n = 1'b1;
      #1;
      chk("idle_in_ready", 64'(in_ready), 64'd1);

      // zero word: latency and busy duration
      send("zero", 64'h0);
      wait_out(1'b0, cyc, bcyc);
      chk("zero_latency", 64'(cyc), 64'd16);
      chk("zero_busy_cycles", 64'(bcyc), 64'd16);
      chk("zero_data", out_data, 64'h0);
      tick();
      chk("zero_drained", 64'(out_valid), 64'd0);

      // ascending nibbles
      w = 64'hFEDC_BA98_7654_3210;
      send("asc", w);
      wait_out(1'b0, cyc, bcyc);
      chk("asc_nib0", 64'(out_data[3:0]), 64'h0);
      chk("asc_nib1", 64'(out_data[7:4]), 64'h6);
      chk("asc_nib2", 64'(out_data[11:8]), 64'he);
      chk("asc_nib15", 64'(out_data[63:60]), 64'hb);
      chk("asc_word", out_data, model(w));
      tick();

      // backpressure
      out_ready = 1'b0;
      w = 64'h0123_4567_89AB_CDEF;
      send("bp", w);
      wait_out(1'b0, cyc, bcyc);
      chk("bp_latency", 64'(cyc), 64'd16);
      held = out_data;
      bad = 0;
      for (int i = 0; i < 10; i++) begin
         if (out_data !== held || in_ready !== 1'b0 || out_valid !== 1'b1) bad++;
         tick();
      end
      chk("bp_stable_cycles_bad", 64'(bad), 64'd0);
      chk("bp_data", out_data, model(w));
      out_ready = 1'b1;
      tick();
      chk("bp_release_valid", 64'(out_valid), 64'd0);
      chk("bp_release_idle", 64'(in_ready), 64'd1);

      // back-to-back with in_valid held high
      in_valid = 1'b1;
      in_data  = 64'hFFFF_FFFF_FFFF_FFFF;
      tick();
      in_data  = 64'h1111_1111_1111_1111;
      wait_out(1'b0, cyc, bcyc);
      chk("b2b_first_latency", 64'(cyc), 64'd16);
      chk("b2b_first_data", out_data, 64'hBBBB_BBBB_BBBB_BBBB);
      chk("b2b_ready_in_done", 64'(in_ready), 64'd1);
      tick();
      in_valid = 1'b0;
      chk("b2b_second_busy", 64'(busy), 64'd1);
      wait_out(1'b0, cyc, bcyc);
      chk("b2b_spacing", 64'(cyc + 1), 64'd17);
      chk("b2b_second_data", out_data, 64'h6666_6666_6666_6666);
      tick();
      chk("b2b_drained", 64'(out_valid), 64'd0);

      // reset mid-RUN at cnt=7
      send("abort", 64'hA5A5_A5A5_A5A5_A5A5);
      for (int i = 0; i < 7; i++) tick();
      chk("abort_cnt", 64'(dut.cnt), 64'd7);
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      #1;
      chk("abort_out_valid", 64'(out_valid), 64'd0);
      chk("abort_out_data", out_data, 64'h0);
      chk("abort_busy", 64'(busy), 64'd0);
      chk("abort_idle", 64'(in_ready), 64'd1);
      w = 64'h0F1E_2D3C_4B5A_6978;
      send("post_abort", w);
      wait_out(1'b0, cyc, bcyc);
      chk("post_abort_latency", 64'(cyc), 64'd16);
      chk("post_abort_data", out_data, model(w));
      tick();

      // in_data scrambled during RUN
      w = 64'hC0FF_EE12_3456_789A;
      send("scr", w);
      wait_out(1'b1, cyc, bcyc);
      chk("scr_data", out_data, model(w));
      tick();

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
